// File: rtl/cfg_unpack_shadow.sv
// Config word unpacker with commit-toggle shadowing, stretched active-low block resets and per-channel bias.
// Optional bias saturation is enabled with `define CFG_UNPACK_BIAS_CLAMP_EN.
module cfg_unpack_shadow #(
  parameter int unsigned CFG_DATA_WIDTH = 256,
  parameter int unsigned NUM_RST        = 8,
  parameter int unsigned RST_LSB        = 0,
  parameter int unsigned RST_HOLD       = 16,
  parameter int unsigned RATE_LSB       = 16,
  parameter int unsigned RATE_WIDTH     = 16,
  parameter int unsigned ADDR_LSB       = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TRG_LSB        = 64,
  parameter int unsigned TRG_WIDTH      = 16,
  parameter int unsigned LIMITER_LSB    = 80,
  parameter int unsigned LIMITER_WIDTH  = 8,
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned BIAS_LSB       = 96,
  parameter int unsigned BIAS_WIDTH     = 16,
  parameter int unsigned COMMIT_BIT     = 255,
  parameter int unsigned BIAS_LIMIT     = 8191
) (
  input  logic                           aclk,
  input  logic                           rst,
  input  logic [CFG_DATA_WIDTH-1:0]      cfg_data,
  output logic [NUM_RST-1:0]             nreset,
  output logic [RATE_WIDTH-1:0]          rx_rate,
  output logic [ADDR_WIDTH-1:0]          rx_addr,
  output logic [TRG_WIDTH-1:0]           trg_value,
  output logic [LIMITER_WIDTH-1:0]       limiter,
  output logic [NUM_CH*BIAS_WIDTH-1:0]   bias,
  output logic                           cfg_updated,
  output logic [15:0]                    commit_count,
  output logic                           bias_clamped
);

  localparam int unsigned BIAS_TOTAL = NUM_CH * BIAS_WIDTH;
  localparam int unsigned CNT_W      = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

  function automatic bit fits(input int unsigned lsb, input int unsigned w);
    return (lsb + w) <= CFG_DATA_WIDTH;
  endfunction

  function automatic bit hits(input int unsigned lsb, input int unsigned w);
    return (COMMIT_BIT >= lsb) && (COMMIT_BIT < lsb + w);
  endfunction

  // Parameter sanity: fields inside the word, commit bit clear of every field.
  if (!(fits(RST_LSB, NUM_RST) && fits(RATE_LSB, RATE_WIDTH) && fits(ADDR_LSB, ADDR_WIDTH) &&
        fits(TRG_LSB, TRG_WIDTH) && fits(LIMITER_LSB, LIMITER_WIDTH) &&
        fits(BIAS_LSB, BIAS_TOTAL) && (COMMIT_BIT < CFG_DATA_WIDTH))) begin : g_bad_fit
    $error("cfg_unpack_shadow: a field lies outside cfg_data");
  end
  if (hits(RST_LSB, NUM_RST) || hits(RATE_LSB, RATE_WIDTH) || hits(ADDR_LSB, ADDR_WIDTH) ||
      hits(TRG_LSB, TRG_WIDTH) || hits(LIMITER_LSB, LIMITER_WIDTH) ||
      hits(BIAS_LSB, BIAS_TOTAL)) begin : g_bad_commit
    $error("cfg_unpack_shadow: COMMIT_BIT overlaps a field");
  end
  if (BIAS_LIMIT >= (2 ** (BIAS_WIDTH - 1))) begin : g_bad_limit
    $error("cfg_unpack_shadow: BIAS_LIMIT does not fit a signed BIAS_WIDTH value");
  end

  logic [CFG_DATA_WIDTH-1:0] cfg_q;
  logic                      commit_prev;
  logic                      commit_c;
  logic [BIAS_TOTAL-1:0]     bias_next_c;
  logic [CNT_W-1:0]          hold_cnt [NUM_RST];
  logic                      unused_c;

  assign unused_c = ^cfg_q;
  assign commit_c = cfg_q[COMMIT_BIT] ^ commit_prev;

  // Input capture and commit-edge history.
  always_ff @(posedge aclk) begin
    if (rst) begin
      cfg_q       <= '0;
      commit_prev <= 1'b0;
    end else begin
      cfg_q       <= cfg_data;
      commit_prev <= cfg_q[COMMIT_BIT];
    end
  end

`ifdef CFG_UNPACK_BIAS_CLAMP_EN
  localparam logic signed [BIAS_WIDTH-1:0] LIM_P = BIAS_WIDTH'(BIAS_LIMIT);
  localparam logic signed [BIAS_WIDTH-1:0] LIM_N = -LIM_P;

  logic clamp_hit_c;

  // Saturate each channel to +/-BIAS_LIMIT on the way into the shadow.
  always_comb begin
    bias_next_c = cfg_q[BIAS_LSB +: BIAS_TOTAL];
    clamp_hit_c = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if ($signed(bias_next_c[k*BIAS_WIDTH +: BIAS_WIDTH]) > LIM_P) begin
        bias_next_c[k*BIAS_WIDTH +: BIAS_WIDTH] = LIM_P;
        clamp_hit_c = 1'b1;
      end else if ($signed(bias_next_c[k*BIAS_WIDTH +: BIAS_WIDTH]) < LIM_N) begin
        bias_next_c[k*BIAS_WIDTH +: BIAS_WIDTH] = LIM_N;
        clamp_hit_c = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      bias_clamped <= 1'b0;
    end else if (commit_c) begin
      bias_clamped <= bias_clamped | clamp_hit_c;
    end
  end
`else
  assign bias_next_c  = cfg_q[BIAS_LSB +: BIAS_TOTAL];
  assign bias_clamped = 1'b0;
`endif

  // Shadow registers load only on a commit-bit toggle.
  always_ff @(posedge aclk) begin
    if (rst) begin
      rx_rate      <= '0;
      rx_addr      <= '0;
      trg_value    <= '0;
      limiter      <= '0;
      bias         <= '0;
      cfg_updated  <= 1'b0;
      commit_count <= '0;
    end else begin
      cfg_updated <= commit_c;
      if (commit_c) begin
        rx_rate      <= cfg_q[RATE_LSB +: RATE_WIDTH];
        rx_addr      <= cfg_q[ADDR_LSB +: ADDR_WIDTH];
        trg_value    <= cfg_q[TRG_LSB +: TRG_WIDTH];
        limiter      <= cfg_q[LIMITER_LSB +: LIMITER_WIDTH];
        bias         <= bias_next_c;
        commit_count <= commit_count + 16'd1;
      end
    end
  end

  // Per-bit reset stretch: any low sample reloads the hold counter.
  always_ff @(posedge aclk) begin
    if (rst) begin
      nreset <= '0;
      for (int i = 0; i < NUM_RST; i++) hold_cnt[i] <= CNT_W'(RST_HOLD);
    end else begin
      for (int i = 0; i < NUM_RST; i++) begin
        if (!cfg_q[RST_LSB + i]) begin
          nreset[i]   <= 1'b0;
          hold_cnt[i] <= CNT_W'(RST_HOLD);
        end else if (hold_cnt[i] != '0) begin
          nreset[i]   <= 1'b0;
          hold_cnt[i] <= hold_cnt[i] - CNT_W'(1);
        end else begin
          nreset[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cfg_unpack_shadow.sv
// Self-checking bench for cfg_unpack_shadow: history-window reference model plus directed and random stimulus.
// Build with or without `define CFG_UNPACK_BIAS_CLAMP_EN; the model follows the same macro.
module tb_cfg_unpack_shadow;

  localparam int HOLD  = 16;
  localparam int CB    = 255;
  localparam int LIMIT = 8191;

  logic         aclk = 1'b0;
  logic         rst  = 1'b1;
  logic [255:0] cfg_data = '0;
  logic [7:0]   nreset;
  logic [15:0]  rx_rate;
  logic [31:0]  rx_addr;
  logic [15:0]  trg_value;
  logic [7:0]   limiter;
  logic [63:0]  bias;
  logic         cfg_updated;
  logic [15:0]  commit_count;
  logic         bias_clamped;

  int errors = 0;
  int checks = 0;

  cfg_unpack_shadow dut (
    .aclk(aclk), .rst(rst), .cfg_data(cfg_data), .nreset(nreset),
    .rx_rate(rx_rate), .rx_addr(rx_addr), .trg_value(trg_value), .limiter(limiter),
    .bias(bias), .cfg_updated(cfg_updated), .commit_count(commit_count),
    .bias_clamped(bias_clamped)
  );

  always #5 aclk = ~aclk;

  // Reference model: outputs derived from a window of sampled cfg words.
  logic [255:0] qh [64] = '{default: '0};
  logic         rh [64] = '{default: 1'b1};
  int           e = 0;
  logic         m_valid = 1'b0;
  logic [7:0]   m_nrst = '0;
  logic [15:0]  m_rate = '0, m_trg = '0, m_cnt = '0;
  logic [31:0]  m_addr = '0;
  logic [7:0]   m_lim = '0;
  logic [63:0]  m_bias = '0;
  logic         m_upd = 1'b0, m_clamped = 1'b0;

  always @(posedge aclk) begin : p_model
    logic [255:0] qn, q1, q2;
    logic [63:0]  nb;
    logic         r1, ok, cl;
    int           b;
    qn = rst ? '0 : cfg_data;
    q1 = qh[(e - 1) & 63];
    q2 = qh[(e - 2) & 63];
    r1 = rh[(e - 1) & 63];
    cl = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b = int'($signed(q1[96 + 16*k +: 16]));
`ifdef CFG_UNPACK_BIAS_CLAMP_EN
      if (b > LIMIT) begin b = LIMIT; cl = 1'b1; end
      else if (b < -LIMIT) begin b = -LIMIT; cl = 1'b1; end
`endif
      nb[16*k +: 16] = 16'(b);
    end
    if (rst) begin
      m_valid <= 1'b1;
      m_rate <= '0; m_addr <= '0; m_trg <= '0; m_lim <= '0; m_bias <= '0;
      m_upd <= 1'b0; m_cnt <= '0; m_clamped <= 1'b0;
    end else if (!r1 && (q1[CB] != q2[CB])) begin
      m_rate <= q1[31:16]; m_addr <= q1[63:32]; m_trg <= q1[79:64]; m_lim <= q1[87:80];
      m_bias <= nb; m_upd <= 1'b1; m_cnt <= m_cnt + 16'd1;
      m_clamped <= m_clamped | cl;
    end else begin
      m_upd <= 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      ok = 1'b1;
      for (int j = 0; j <= HOLD; j++) ok = ok & qh[(e - 1 - j) & 63][i];
      m_nrst[i] <= rst ? 1'b0 : ok;
    end
    qh[e & 63] <= qn;
    rh[e & 63] <= rst;
    e <= e + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge aclk) begin
    if (m_valid) begin
      chk("nreset", 64'(nreset), 64'(m_nrst));
      chk("rx_rate", 64'(rx_rate), 64'(m_rate));
      chk("rx_addr", 64'(rx_addr), 64'(m_addr));
      chk("trg_value", 64'(trg_value), 64'(m_trg));
      chk("limiter", 64'(limiter), 64'(m_lim));
      chk("bias", bias, m_bias);
      chk("cfg_updated", 64'(cfg_updated), 64'(m_upd));
      chk("commit_count", 64'(commit_count), 64'(m_cnt));
      chk("bias_clamped", 64'(bias_clamped), 64'(m_clamped));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic toggle();
    cfg_data[CB] = ~cfg_data[CB];
  endtask

  initial begin
    #3000000;
    $display("FAIL timeout: got no finish expected finish before 3ms");
    $fatal(1);
  end

  initial begin : p_stim
    int low, others, pulses;
    logic [255:0] r;
    // Reset and defaults
    cfg_data = '0;
    cfg_data[7:0] = 8'hFF;
    cfg_data[31:16] = 16'h0100;
    rst = 1'b1;
    cyc(3);
    chk("lit_reset_nreset", 64'(nreset), 64'h0);
    chk("lit_reset_rate", 64'(rx_rate), 64'h0);
    rst = 1'b0;
    cyc(20);
    chk("lit_no_toggle_rate", 64'(rx_rate), 64'h0);
    chk("lit_no_toggle_cnt", 64'(commit_count), 64'h0);
    chk("lit_nreset_released", 64'(nreset), 64'hFF);

    // First commit: two edges later
    toggle();
    cyc(1);
    chk("lit_commit_not_early", 64'(cfg_updated), 64'h0);
    cyc(1);
    chk("lit_commit_rate", 64'(rx_rate), 64'h0100);
    chk("lit_commit_upd", 64'(cfg_updated), 64'h1);
    chk("lit_commit_cnt", 64'(commit_count), 64'h1);
    chk("lit_model_rate", 64'(m_rate), 64'h0100);

    // Change without toggle, then back-to-back toggles
    cfg_data[63:32] = 32'hDEADBEEF;
    cyc(4);
    chk("lit_addr_untouched", 64'(rx_addr), 64'h0);
    cfg_data[63:32] = 32'h1; toggle();
    cyc(1);
    cfg_data[63:32] = 32'h2; toggle();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (i == 0) chk("lit_addr_first", 64'(rx_addr), 64'h1);
      if (cfg_updated) pulses++;
    end
    chk("lit_b2b_pulses", 64'(pulses), 64'd2);
    chk("lit_b2b_addr", 64'(rx_addr), 64'h2);
    chk("lit_b2b_cnt", 64'(commit_count), 64'h3);

    // One-cycle low on reset bit 2
    cfg_data[2] = 1'b0;
    cyc(1);
    cfg_data[2] = 1'b1;
    low = 0; others = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (!nreset[2]) low++;
      if ((nreset | 8'h04) != 8'hFF) others++;
    end
    chk("lit_stretch_len", 64'(low), 64'd17);
    chk("lit_stretch_others", 64'(others), 64'd0);

    // Re-assert mid-hold extends the low period
    cfg_data[2] = 1'b0;
    cyc(1);
    cfg_data[2] = 1'b1;
    low = 0;
    for (int i = 2; i < 46; i++) begin
      cyc(1);
      if (!nreset[2]) low++;
      if (i == 10) cfg_data[2] = 1'b0;
      if (i == 11) cfg_data[2] = 1'b1;
    end
    chk("lit_restretch_len", 64'(low), 64'd27);

    // Bias extremes
    cfg_data[159:96] = {16'h8000, 16'h0000, 16'h0000, 16'h7FFF};
    toggle();
    cyc(2);
`ifdef CFG_UNPACK_BIAS_CLAMP_EN
    chk("lit_bias", bias, {16'hE001, 16'h0000, 16'h0000, 16'h1FFF});
    chk("lit_bias_clamped", 64'(bias_clamped), 64'h1);
`else
    chk("lit_bias", bias, {16'h8000, 16'h0000, 16'h0000, 16'h7FFF});
    chk("lit_bias_clamped", 64'(bias_clamped), 64'h0);
`endif
    chk("lit_bias_cnt", 64'(commit_count), 64'h4);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
      r[CB] = cfg_data[CB] ^ ($urandom_range(0, 2) == 0);
      r[7:0] = 8'hFF;
      if ($urandom_range(0, 7) == 0) r[$urandom_range(0, 7)] = 1'b0;
      cfg_data = r;
      rst = ($urandom_range(0, 63) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cfg_data[7:0] = 8'hFF;
    cyc(20);

    // Reset mid-hold with committed outputs, released with commit bit high
    cfg_data[0] = 1'b0;
    cfg_data[31:16] = 16'h1234;
    toggle();
    cyc(1);
    cfg_data[0] = 1'b1;
    cyc(5);
    cfg_data[CB] = 1'b1;
    rst = 1'b1;
    cyc(1);
    chk("lit_rst_nreset", 64'(nreset), 64'h0);
    chk("lit_rst_rate", 64'(rx_rate), 64'h0);
    chk("lit_rst_cnt", 64'(commit_count), 64'h0);
    rst = 1'b0;
    cyc(2);
    chk("lit_rst_commit_upd", 64'(cfg_updated), 64'h1);
    chk("lit_rst_commit_cnt", 64'(commit_count), 64'h1);
    cyc(3);
    chk("lit_rst_single_commit", 64'(commit_count), 64'h1);

    // Counter wrap: 65537 commits from zero
    cfg_data[CB] = 1'b0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(3);
    chk("lit_wrap_start", 64'(commit_count), 64'h0);
    for (int n = 0; n < 65537; n++) begin
      toggle();
      cyc(1);
    end
    cyc(3);
    chk("lit_wrap_cnt", 64'(commit_count), 64'h1);
    chk("lit_wrap_model", 64'(m_cnt), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
